// File: rtl/relu_act_pkg.sv
// Shared widths, types and helpers for the quantizing ReLU activation stage.
package relu_act_pkg;

    localparam int unsigned DEF_IN_W  = 12;
    localparam int unsigned DEF_OUT_W = 5;
    localparam int unsigned DEF_SHIFT = 6;
    localparam int unsigned OUT_MAX   = (2 ** DEF_OUT_W) - 1;

    typedef logic signed [DEF_IN_W-1:0] acc_t;
    typedef logic        [DEF_OUT_W-1:0] act_t;

    // Half-LSB bias added before the shift when rounding is enabled.
    function automatic int unsigned round_bias(input int unsigned shift, input int unsigned round);
        return (round != 0 && shift > 0) ? (32'd1 << (shift - 1)) : 32'd0;
    endfunction

endpackage

// File: rtl/relu_quant_core.sv
// Combinational ReLU quantizer: sign clamp, optional rounding, right shift, saturate.
module relu_quant_core
    import relu_act_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned SHIFT = DEF_SHIFT,
    parameter int unsigned ROUND = 0
) (
    input  logic [IN_W-1:0]  data,
    output logic [OUT_W-1:0] act_c,
    output logic             sat_c
);

    // One extra bit keeps the rounding add from overflowing.
    localparam int unsigned T_W = IN_W + 1;
    localparam logic [T_W-1:0] BIAS  = T_W'(round_bias(SHIFT, ROUND));
    localparam logic [T_W-1:0] MAX_T = T_W'((2 ** OUT_W) - 1);

    logic [T_W-1:0] t;
    logic [T_W-1:0] s;

    always_comb begin
        t     = {1'b0, data} + BIAS;
        s     = t >> SHIFT;
        act_c = '0;
        sat_c = 1'b0;
        if (!data[IN_W-1]) begin
            if (s > MAX_T) begin
                act_c = OUT_W'(MAX_T);
                sat_c = 1'b1;
            end else begin
                act_c = OUT_W'(s);
            end
        end
    end

endmodule

// File: rtl/relu_activation.sv
// Registered quantizing ReLU stage between the accumulator and the next layer input.
module relu_activation
    import relu_act_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned OUT_W = DEF_OUT_W,
    parameter int unsigned SHIFT = DEF_SHIFT,
    parameter int unsigned ROUND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  data_in,
    output logic             out_valid,
    output logic [OUT_W-1:0] data_out,
    output logic             sat
);

    logic [OUT_W-1:0] act_c;
    logic             sat_c;

    relu_quant_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT),
        .ROUND (ROUND)
    ) u_core (
        .data  (data_in),
        .act_c (act_c),
        .sat_c (sat_c)
    );

    // Result and flag hold while no new input is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sat       <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= act_c;
                sat      <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_relu_activation.sv
// Self-checking bench: three parameterisations driven in parallel against an integer model.
module tb_relu_activation;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] data_in = '0;

    logic       v0, v1, v2;
    logic [4:0] o0, o1, o2;
    logic       s0, s1, s2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    relu_activation #(.IN_W(12), .OUT_W(5), .SHIFT(6), .ROUND(0)) u_def (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .out_valid(v0), .data_out(o0), .sat(s0));

    relu_activation #(.IN_W(12), .OUT_W(5), .SHIFT(4), .ROUND(0)) u_sh4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .out_valid(v1), .data_out(o1), .sat(s1));

    relu_activation #(.IN_W(12), .OUT_W(5), .SHIFT(6), .ROUND(1)) u_rnd (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data_in(data_in),
        .out_valid(v2), .data_out(o2), .sat(s2));

    // Expected {activation, sat} from plain integer arithmetic.
    function automatic logic [5:0] model(input logic [11:0] x, input int sh, input int rnd);
        int v;
        v = int'($signed(x));
        if (v < 0) return 6'd0;
        if (rnd != 0 && sh > 0) v = v + (1 << (sh - 1));
        v = v / (1 << sh);
        if (v > 31) return {5'd31, 1'b1};
        return {v[4:0], 1'b0};
    endfunction

    logic       exp_v;
    logic [5:0] exp0, exp1, exp2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_v <= 1'b0;
            exp0  <= '0;
            exp1  <= '0;
            exp2  <= '0;
        end else begin
            exp_v <= in_valid;
            if (in_valid) begin
                exp0 <= model(data_in, 6, 0);
                exp1 <= model(data_in, 4, 0);
                exp2 <= model(data_in, 6, 1);
            end
        end
    end

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got act=%0d sat=%0d, want act=%0d sat=%0d @%0t",
                     nm, act[5:1], act[0], exp[5:1], exp[0], $time);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, want %0b @%0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk_bit("model out_valid", v0, exp_v);
        chk_bit("model out_valid sh4", v1, exp_v);
        chk_bit("model out_valid rnd", v2, exp_v);
        chk("model def", {o0, s0}, exp0);
        chk("model sh4", {o1, s1}, exp1);
        chk("model rnd", {o2, s2}, exp2);
    end

    task automatic drive(input logic v, input logic [11:0] x);
        in_valid = v;
        data_in  = x;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #12;
        chk("reset def", {o0, s0}, 6'd0);
        chk_bit("reset out_valid", v0, 1'b0);
        rst_n = 1'b1;

        drive(1'b1, 12'hF05);
        chk_bit("neg valid", v0, 1'b1);
        chk("neg def", {o0, s0}, {5'd0, 1'b0});
        chk("neg sh4", {o1, s1}, {5'd0, 1'b0});
        chk("neg rnd", {o2, s2}, {5'd0, 1'b0});

        drive(1'b1, 12'h549);
        chk("549 def", {o0, s0}, {5'd21, 1'b0});
        chk("549 sh4", {o1, s1}, {5'd31, 1'b1});
        chk("549 rnd", {o2, s2}, {5'd21, 1'b0});

        drive(1'b1, 12'h7FF);
        chk("7ff def", {o0, s0}, {5'd31, 1'b0});
        chk("7ff sh4", {o1, s1}, {5'd31, 1'b1});
        chk("7ff rnd", {o2, s2}, {5'd31, 1'b1});

        drive(1'b1, 12'h000);
        chk("zero def", {o0, s0}, {5'd0, 1'b0});
        chk("zero sh4", {o1, s1}, {5'd0, 1'b0});

        drive(1'b1, 12'h1F0);
        chk("1f0 sh4", {o1, s1}, {5'd31, 1'b0});
        chk("1f0 def", {o0, s0}, {5'd7, 1'b0});
        chk("1f0 rnd", {o2, s2}, {5'd8, 1'b0});

        drive(1'b1, 12'h1F8);
        chk("1f8 sh4", {o1, s1}, {5'd31, 1'b0});

        drive(1'b1, 12'h200);
        chk("200 sh4", {o1, s1}, {5'd31, 1'b1});

        drive(1'b1, 12'h01F);
        chk("01f rnd", {o2, s2}, {5'd0, 1'b0});

        drive(1'b1, 12'h020);
        chk("020 rnd", {o2, s2}, {5'd1, 1'b0});
        chk("020 def", {o0, s0}, {5'd0, 1'b0});

        drive(1'b1, 12'h800);
        chk("800 def", {o0, s0}, {5'd0, 1'b0});
        chk("800 rnd", {o2, s2}, {5'd0, 1'b0});

        // Hold: idle inputs must not disturb the last result.
        drive(1'b1, 12'h549);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 12'h7FF);
            chk_bit("hold out_valid", v0, 1'b0);
            chk("hold def", {o0, s0}, {5'd21, 1'b0});
        end

        // Asynchronous reset between clock edges.
        drive(1'b1, 12'h549);
        drive(1'b1, 12'h7FF);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst sh4", {o1, s1}, {5'd0, 1'b0});
        chk("async rst def", {o0, s0}, {5'd0, 1'b0});
        chk_bit("async rst out_valid", v0, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk_bit("post rst idle", v0, 1'b0);
        drive(1'b1, 12'h549);
        chk_bit("post rst valid", v0, 1'b1);
        chk("post rst def", {o0, s0}, {5'd21, 1'b0});

        drive(1'b0, 12'h000);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
